// File: rtl/motor_drive_ramp.sv
// motor_drive_ramp: slews a signed drive command into PWM duty plus H-bridge enables,
// with coast-through-zero on reversal and an active brake mode. Rev 1.0
`default_nettype none

module motor_drive_ramp #(
  parameter int SLEW_STEP  = 16,
  parameter int TICK_DIV   = 1024,
  parameter int DEAD_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_vld,
  input  logic [10:0] cmd,
  input  logic        brake_req,
  output logic [9:0]  duty,
  output logic        fwd,
  output logic        rev,
  output logic        settled
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEAD_TICKS + 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [10:0]   STEP11    = 11'(SLEW_STEP);
  localparam logic [9:0]    STEP10    = 10'(SLEW_STEP);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DEAD, S_BRAKE} state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt;
  logic [9:0]    r_cur, w_cur;
  logic          r_dir, w_dir;
  logic [DW-1:0] r_dead, w_dead;
  logic          r_tgt_neg, w_tgt_neg;
  logic [9:0]    r_tgt_mag, w_tgt_mag;

  logic          w_tick;
  logic [10:0]   w_cmd_abs;
  logic [9:0]    w_cmd_mag;
  logic [9:0]    w_start;
  logic [10:0]   w_sum;
  logic [10:0]   w_diff;
  logic [9:0]    w_slew;
  logic [9:0]    w_duty;
  logic          w_fwd, w_rev, w_settled;

  assign w_tick = (r_cnt == TICK_LAST);

  // -1024 has no positive 10-bit counterpart, so it saturates to full scale
  assign w_cmd_abs = cmd[10] ? (~cmd + 11'd1) : cmd;
  assign w_cmd_mag = w_cmd_abs[10] ? 10'd1023 : w_cmd_abs[9:0];
  assign w_tgt_neg = cmd_vld ? cmd[10]   : r_tgt_neg;
  assign w_tgt_mag = cmd_vld ? w_cmd_mag : r_tgt_mag;

  assign w_start = ({1'b0, r_tgt_mag} > STEP11) ? STEP10 : r_tgt_mag;
  assign w_sum   = {1'b0, r_cur} + STEP11;
  assign w_diff  = {1'b0, r_cur} - {1'b0, r_tgt_mag};

  always_comb begin
    w_slew = r_cur;
    if (r_cur < r_tgt_mag)
      w_slew = (w_sum > {1'b0, r_tgt_mag}) ? r_tgt_mag : w_sum[9:0];
    else if (r_cur > r_tgt_mag)
      w_slew = (w_diff > STEP11) ? (r_cur - STEP10) : r_tgt_mag;
  end

  always_comb begin
    w_state = r_state;
    w_cur   = r_cur;
    w_dir   = r_dir;
    w_dead  = r_dead;
    if (brake_req) begin
      w_state = S_BRAKE;
      w_cur   = 10'd0;
    end else if (r_state == S_BRAKE) begin
      w_state = S_DEAD;
      w_dead  = DEAD_LOAD;
    end else if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (r_tgt_mag != 10'd0) begin
            w_state = S_DRIVE;
            w_dir   = r_tgt_neg;
            w_cur   = w_start;
          end
        end
        S_DRIVE: begin
          if (r_tgt_mag != 10'd0 && r_dir == r_tgt_neg) begin
            w_cur = w_slew;
          end else if (r_cur <= STEP10) begin
            w_cur   = 10'd0;
            w_state = S_DEAD;
            w_dead  = DEAD_LOAD;
          end else begin
            w_cur = r_cur - STEP10;
          end
        end
        S_DEAD: begin
          if (r_dead <= DW'(1)) begin
            w_dead = '0;
            if (r_tgt_mag != 10'd0) begin
              w_state = S_DRIVE;
              w_dir   = r_tgt_neg;
              w_cur   = w_start;
            end else begin
              w_state = S_IDLE;
            end
          end else begin
            w_dead = r_dead - DW'(1);
          end
        end
        default: w_state = r_state;
      endcase
    end
  end

  // Outputs are derived from next-state values so they register on the same edge
  always_comb begin
    w_duty = 10'd1;
    w_fwd  = 1'b0;
    w_rev  = 1'b0;
    case (w_state)
      S_DRIVE: begin
        w_duty = (w_cur == 10'd0) ? 10'd1 : w_cur;
        w_fwd  = ~w_dir;
        w_rev  = w_dir;
      end
      S_BRAKE: begin
        w_duty = 10'd0;
        w_fwd  = 1'b1;
        w_rev  = 1'b1;
      end
      default: begin
        w_duty = 10'd1;
        w_fwd  = 1'b0;
        w_rev  = 1'b0;
      end
    endcase
    w_settled = ((w_state == S_DRIVE) && (w_cur == w_tgt_mag) && (w_dir == w_tgt_neg)) ||
                ((w_state == S_IDLE) && (w_tgt_mag == 10'd0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_state   <= S_IDLE;
      r_cur     <= 10'd0;
      r_dir     <= 1'b0;
      r_dead    <= '0;
      r_tgt_neg <= 1'b0;
      r_tgt_mag <= 10'd0;
      duty      <= 10'd1;
      fwd       <= 1'b0;
      rev       <= 1'b0;
      settled   <= 1'b1;
    end else begin
      r_cnt     <= w_tick ? '0 : r_cnt + CW'(1);
      r_state   <= w_state;
      r_cur     <= w_cur;
      r_dir     <= w_dir;
      r_dead    <= w_dead;
      r_tgt_neg <= w_tgt_neg;
      r_tgt_mag <= w_tgt_mag;
      duty      <= w_duty;
      fwd       <= w_fwd;
      rev       <= w_rev;
      settled   <= w_settled;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_motor_drive_ramp.sv
// tb_motor_drive_ramp: tick-by-tick vector table plus hand sequences for reset,
// brake latency and command timing, with TICK_DIV=8, SLEW_STEP=100, DEAD_TICKS=2.
`default_nettype none

module tb_motor_drive_ramp;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_vld;
  logic [10:0] cmd;
  logic        brake_req;
  logic [9:0]  duty;
  logic        fwd, rev, settled;

  int nvec  = 0;
  int nfail = 0;

  logic [2:0] bcnt;

  typedef struct {
    bit         vld;
    logic [10:0] cmd;
    bit         brk;
    logic [9:0] duty;
    bit         fwd;
    bit         rev;
    bit         set;
  } vec_t;

  vec_t vq[$];

  motor_drive_ramp #(
    .SLEW_STEP (100),
    .TICK_DIV  (8),
    .DEAD_TICKS(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_vld  (cmd_vld),
    .cmd      (cmd),
    .brake_req(brake_req),
    .duty     (duty),
    .fwd      (fwd),
    .rev      (rev),
    .settled  (settled)
  );

  always #5 clk = ~clk;

  // Expected tick schedule: the tick edge is the one ending a cycle with bcnt == 7
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bcnt <= 3'd0;
    else     bcnt <= bcnt + 3'd1;
  end

  function automatic void add(bit v, int c, bit b, int d, bit f, bit r, bit s);
    vec_t e;
    e.vld  = v;
    e.cmd  = 11'(c);
    e.brk  = b;
    e.duty = 10'(d);
    e.fwd  = f;
    e.rev  = r;
    e.set  = s;
    vq.push_back(e);
  endfunction

  task automatic check(string name, int d, bit f, bit r, bit s);
    nvec++;
    if (duty !== 10'(d) || fwd !== f || rev !== r || settled !== s) begin
      nfail++;
      $display("FAIL %s: got duty=%0d fwd=%0b rev=%0b settled=%0b, expected duty=%0d fwd=%0b rev=%0b settled=%0b",
               name, duty, fwd, rev, settled, d, f, r, s);
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    while (bcnt != 3'd7 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bcnt != 3'd7) begin
      nvec++;
      nfail++;
      $display("FAIL tick_timeout: got no tick within %0d clocks, expected one within 8", n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic release_check(string tag);
    @(negedge clk);
    rst       = 1'b0;
    brake_req = 1'b0;
    cmd_vld   = 1'b1;
    cmd       = 11'd350;
    @(negedge clk);
    cmd_vld = 1'b0;
    repeat (6) @(posedge clk);
    #1 check({tag, "_before_tick"}, 1, 0, 0, 0);
    @(posedge clk);
    #1 check({tag, "_first_tick"}, 100, 1, 0, 0);
  endtask

  initial begin
    // Table continues from duty=100 forward after the startup sequence
    add(0, 0, 0, 200, 1, 0, 0);
    add(0, 0, 0, 300, 1, 0, 0);
    add(0, 0, 0, 350, 1, 0, 1);
    add(0, 0, 0, 350, 1, 0, 1);
    add(1, -200, 0, 250, 1, 0, 0);
    add(0, 0, 0, 150, 1, 0, 0);
    add(0, 0, 0, 50, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 100, 0, 1, 0);
    add(0, 0, 0, 200, 0, 1, 1);
    add(1, 0, 0, 100, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1);
    add(1, 500, 0, 100, 1, 0, 0);
    add(0, 0, 0, 200, 1, 0, 0);
    add(0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 100, 1, 0, 0);
    add(0, 0, 0, 200, 1, 0, 0);
    add(1, -1024, 0, 100, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 10; k++) add(0, 0, 0, 100 * k, 0, 1, 0);
    add(0, 0, 0, 1023, 0, 1, 1);
    add(0, 0, 0, 1023, 0, 1, 1);
    add(1, 1023, 0, 923, 0, 1, 0);
    for (int k = 1; k <= 9; k++) add(0, 0, 0, 923 - 100 * k, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 10; k++) add(0, 0, 0, 100 * k, 1, 0, 0);
    add(0, 0, 0, 1023, 1, 0, 1);
    add(1, 0, 0, 923, 1, 0, 0);
    for (int k = 1; k <= 9; k++) add(0, 0, 0, 923 - 100 * k, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1);

    rst       = 1'b1;
    cmd_vld   = 1'b0;
    cmd       = 11'd0;
    brake_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset", 1, 0, 0, 1);
    release_check("startup");

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      brake_req = vq[i].brk;
      if (vq[i].vld) begin
        cmd_vld = 1'b1;
        cmd     = vq[i].cmd;
        @(negedge clk);
        cmd_vld = 1'b0;
      end
      wait_tick();
      check($sformatf("row%0d", i), int'(vq[i].duty), vq[i].fwd, vq[i].rev, vq[i].set);
    end

    // Two commands inside one tick period: only the last one counts
    @(negedge clk);
    cmd_vld = 1'b1;
    cmd     = 11'd500;
    @(negedge clk);
    cmd     = 11'd100;
    @(negedge clk);
    cmd_vld = 1'b0;
    wait_tick();
    check("last_cmd_wins", 100, 1, 0, 1);

    // Command presented in the tick cycle itself is deferred to the next tick
    for (int n = 0; n < 20 && bcnt != 3'd7; n++) @(negedge clk);
    cmd_vld = 1'b1;
    cmd     = 11'd300;
    @(posedge clk);
    #1 check("cmd_on_tick", 100, 1, 0, 0);
    @(negedge clk);
    cmd_vld = 1'b0;
    wait_tick();
    check("cmd_on_tick_next", 200, 1, 0, 0);
    wait_tick();
    check("cmd_on_tick_done", 300, 1, 0, 1);

    // Brake takes effect one clock after assertion, release enters coast at once
    @(negedge clk);
    @(negedge clk);
    brake_req = 1'b1;
    @(posedge clk);
    #1 check("brake_latency", 0, 1, 1, 0);
    @(negedge clk);
    brake_req = 1'b0;
    @(posedge clk);
    #1 check("brake_release", 1, 0, 0, 0);
    wait_tick();
    check("brake_dead", 1, 0, 0, 0);
    wait_tick();
    check("brake_resume", 100, 1, 0, 0);

    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("reset_mid_ramp", 1, 0, 0, 1);
    release_check("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/motor_drive_ramp.md
# motor_drive_ramp

- Sits directly upstream of the team's 10-bit PWM peripheral and drives its `duty` input.
- Accepts signed drive commands and slews the PWM magnitude toward each target at a programmable rate, once per PWM period.
- On direction reversal, ramps to zero, coasts for a dead interval, then ramps up in the new direction.
- Supplies H-bridge direction enables and a brake mode. The brake mode uses the downstream convention that `duty == 0` forces the PWM output constantly high.

## Interface
Parameters:
- `SLEW_STEP`, default 16: maximum magnitude change per tick; legal range 1..1023.
- `TICK_DIV`, default 1024: clocks per tick; legal minimum 2. The default equals one PWM period.
- `DEAD_TICKS`, default 4: ticks of coast on reversal or stop; legal minimum 1.

Ports:
- `clk`, input, 1 bit: the single clock.
- `rst`, input, 1 bit: asynchronous, active-high reset.
- `cmd_vld`, input, 1 bit: when high, `cmd` is loaded as the new target.
- `cmd`, input, 11 bits: signed two's-complement drive request, -1024..1023.
- `brake_req`, input, 1 bit: level request for active brake.
- `duty`, output, 10 bits: to the PWM peripheral's `duty` input.
- `fwd`, output, 1 bit: forward bridge enable.
- `rev`, output, 1 bit: reverse bridge enable.
- `settled`, output, 1 bit: the output magnitude equals the target.

## Operation
**Target register**
- `cmd_vld` loads target direction (sign of `cmd`) and target magnitude (`|cmd|`).
- `cmd = -1024` saturates to magnitude 1023.
- Target magnitude 0 means stop.
- The most recent `cmd_vld` wins; there is no queue.

**Tick counter**
- Free-running, 0..`TICK_DIV`-1.
- `tick` is a one-cycle pulse when the count equals `TICK_DIV`-1, then the count wraps to 0.
- State and magnitude (`cur`, 10 bits) update only on tick cycles, except for brake.

**State machine** (all transitions below occur on a tick unless stated otherwise):
- **IDLE**: coast.
  - If target magnitude != 0: go to DRIVE, latch `dir` = target direction, `cur` = min(`SLEW_STEP`, target magnitude).
- **DRIVE**: same direction and target magnitude != 0.
  - `cur` moves toward the target magnitude by at most `SLEW_STEP`, saturating exactly at the target, with no overshoot.
  - Compute in 11 bits so that `cur + SLEW_STEP` never wraps.
- **DRIVE**: opposite direction, or target magnitude = 0.
  - `cur` -= min(`SLEW_STEP`, `cur`).
  - On the tick where `cur` becomes 0: go to DEAD and load the dead counter with `DEAD_TICKS`.
- **DEAD**: the dead counter decrements on each tick.
  - On the tick it reaches 0: if target magnitude != 0, go to DRIVE with the new `dir` and `cur` = min(`SLEW_STEP`, magnitude); otherwise go to IDLE.
  - Target changes during DEAD do not restart the dead counter.
- **BRAKE**: entered from any state on the first clock `brake_req` = 1, independent of tick.
  - Entry clears `cur` to 0.
  - Held while `brake_req` = 1.
  - On release, go to DEAD with the dead counter loaded at that clock; the full dead interval applies.

**Outputs** (all registered):
- IDLE and DEAD: `duty` = 1, `fwd` = `rev` = 0.
- DRIVE: `duty` = `cur`, or 1 if `cur` = 0; `fwd` = (`dir` == +), `rev` = (`dir` == -). `fwd` and `rev` are never both 1.
- BRAKE: `duty` = 0, `fwd` = `rev` = 1.
- `settled` = (DRIVE and `cur` == target magnitude and `dir` == target direction) or (IDLE and target magnitude == 0).

**Reset** (also applies to reset mid-operation):
- State = IDLE, target = 0, `cur` = 0, tick count = 0, dead counter = 0.
- `duty` = 10'd1, `fwd` = 0, `rev` = 0, `settled` = 1.

## Timing
- A `cmd_vld` in cycle n updates the target at edge n+1.
  - A tick in cycle n evaluates the target held before that edge.
  - So a command arriving in the tick cycle takes effect on the following tick.
- State, `cur` and outputs change at the edge ending the tick cycle. `duty` is stable for a full `TICK_DIV` period, so with `TICK_DIV` = 1024 it changes once per PWM period.
- Brake latency: `brake_req` sampled high at edge n gives BRAKE outputs after edge n.
- Release: DEAD is entered at the first edge with `brake_req` = 0.
- First tick after reset deassertion occurs at clock `TICK_DIV`-1.
- Minimum reversal time: ceil(`cur` / `SLEW_STEP`) ticks of ramp-down, then `DEAD_TICKS` ticks of coast.

## Test plan
All scenarios use `TICK_DIV` = 8, `SLEW_STEP` = 100, `DEAD_TICKS` = 2.
- **Reset:** assert `rst` mid-ramp → immediately `duty` = 1, `fwd` = `rev` = 0, `settled` = 1; the first tick after release comes 7 clocks later.
- **Forward ramp:** `cmd` = +350 → on successive ticks `duty` = 100, 200, 300, 350 with `fwd` = 1; `settled` rises with 350; `duty` then holds.
- **Reversal:** from +350, `cmd` = -200 → `duty` = 250, 150, 50; then DEAD (`duty` = 1, `fwd` = `rev` = 0) for 2 ticks; then `rev` = 1 with `duty` = 100, 200; `fwd` and `rev` are never both high.
- **Brake:** `brake_req` during ramp at `duty` = 200 → next clock `duty` = 0, `fwd` = `rev` = 1; on release, 2 dead ticks, then ramp 100, 200, … toward the target.
- **Saturation:** `cmd` = -1024 → `rev` = 1, ramp ends at 1023 (…900, 1000, 1023); `cmd` = +1023 behaves identically with `fwd` = 1.
- **Command timing:**
  - Two commands (+500 then +100) between ticks → only the +100 target applies.
  - A command coinciding with a tick is ignored by that tick and applied on the next one.
